// File: rtl/dmi_jtag_access.sv
// JTAG-side DMI access controller: turns dmi DR updates into valid/ready requests,
// tracks sticky status and supplies capture values. Optional timeout: DMI_ACCESS_TIMEOUT_EN.
module dmi_jtag_access #(
  parameter int ABITS          = 7,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             dmi_update_i,
  input  logic             dmi_capture_i,
  input  logic [ABITS-1:0] dmi_addr_i,
  input  logic [31:0]      dmi_data_i,
  input  logic [1:0]       dmi_op_i,
  input  logic             dmi_reset_i,
  input  logic             dmi_hardreset_i,
  output logic [ABITS-1:0] capture_addr_o,
  output logic [31:0]      capture_data_o,
  output logic [1:0]       capture_status_o,
  output logic             busy_o,
  output logic [1:0]       err_o,
  output logic             dmi_req_valid_o,
  input  logic             dmi_req_ready_i,
  output logic [ABITS-1:0] dmi_req_addr_o,
  output logic [1:0]       dmi_req_op_o,
  output logic [31:0]      dmi_req_data_o,
  input  logic             dmi_resp_valid_i,
  output logic             dmi_resp_ready_o,
  input  logic [31:0]      dmi_resp_data_i,
  input  logic [1:0]       dmi_resp_resp_i
);
  // Handshake: a transfer occurs in any cycle where valid and ready are both 1;
  // the request stays valid with stable fields until accepted.
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2} state_t;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  state_t           state_q, state_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       err_q, err_d, err_base;
  logic [ABITS-1:0] cap_addr_q, cap_addr_d;
  logic [31:0]      cap_data_q, cap_data_d;
  logic [1:0]       cap_status_q, cap_status_d;
  logic             timeout;

`ifdef DMI_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;

  assign timeout = (state_q != ST_IDLE) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   tmo_cnt_q <= '0;
    else if (state_q == ST_IDLE) tmo_cnt_q <= '0;
    else                         tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    op_d         = op_q;
    // dmireset clears first so a same-cycle update sees a clean status
    err_base     = dmi_reset_i ? 2'd0 : err_q;
    err_d        = err_base;
    cap_addr_d   = cap_addr_q;
    cap_data_d   = cap_data_q;
    cap_status_d = cap_status_q;

    if (dmi_capture_i) begin
      cap_addr_d   = addr_q;
      cap_data_d   = data_q;
      cap_status_d = (err_q != 2'd0) ? err_q : ((state_q != ST_IDLE) ? 2'd3 : 2'd0);
    end

    case (state_q)
      ST_IDLE: begin
        if (dmi_update_i && err_base == 2'd0 && (dmi_op_i == OP_READ || dmi_op_i == OP_WRITE)) begin
          addr_d  = dmi_addr_i;
          data_d  = dmi_data_i;
          op_d    = dmi_op_i;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dmi_req_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (dmi_resp_valid_i) begin
          if (op_q == OP_READ) data_d = dmi_resp_data_i;
          if (dmi_resp_resp_i != 2'd0 && err_base == 2'd0)
            err_d = (dmi_resp_resp_i == 2'd1) ? 2'd2 : dmi_resp_resp_i;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An update during an access is a busy violation and outranks the response code
    if (state_q != ST_IDLE && dmi_update_i && err_base == 2'd0) err_d = 2'd3;

    if (timeout && state_d != ST_IDLE) begin
      state_d = ST_IDLE;
      if (err_d == 2'd0) err_d = 2'd2;
    end

    if (dmi_hardreset_i) begin
      state_d      = ST_IDLE;
      err_d        = 2'd0;
      addr_d       = addr_q;
      data_d       = data_q;
      op_d         = op_q;
      cap_addr_d   = cap_addr_q;
      cap_data_d   = cap_data_q;
      cap_status_d = cap_status_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      op_q         <= '0;
      err_q        <= '0;
      cap_addr_q   <= '0;
      cap_data_q   <= '0;
      cap_status_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      op_q         <= op_d;
      err_q        <= err_d;
      cap_addr_q   <= cap_addr_d;
      cap_data_q   <= cap_data_d;
      cap_status_q <= cap_status_d;
    end
  end

  assign capture_addr_o   = cap_addr_q;
  assign capture_data_o   = cap_data_q;
  assign capture_status_o = cap_status_q;
  assign busy_o           = (state_q != ST_IDLE);
  assign err_o            = err_q;
  assign dmi_req_valid_o  = (state_q == ST_REQ);
  assign dmi_req_addr_o   = addr_q;
  assign dmi_req_op_o     = op_q;
  assign dmi_req_data_o   = data_q;
  // Held low while reset is asserted so every output reads 0 in reset
  assign dmi_resp_ready_o = !rst_i && (state_q != ST_REQ);
endmodule

// File: tb/tb_dmi_jtag_access.sv
// Self-checking bench for dmi_jtag_access: reset, vector table, randomized accesses
// against a transaction-level model, and hand-written multi-cycle corner cases.
module tb_dmi_jtag_access;
  localparam int ABITS = 7;
  localparam int TMO   = 8;
  localparam int REQ_W = ABITS + 34;

  logic             clk = 1'b0;
  logic             rst;
  logic             dmi_update_i, dmi_capture_i, dmi_reset_i, dmi_hardreset_i;
  logic [ABITS-1:0] dmi_addr_i;
  logic [31:0]      dmi_data_i;
  logic [1:0]       dmi_op_i;
  logic [ABITS-1:0] capture_addr_o;
  logic [31:0]      capture_data_o;
  logic [1:0]       capture_status_o;
  logic             busy_o;
  logic [1:0]       err_o;
  logic             dmi_req_valid_o, dmi_req_ready_i;
  logic [ABITS-1:0] dmi_req_addr_o;
  logic [1:0]       dmi_req_op_o;
  logic [31:0]      dmi_req_data_o;
  logic             dmi_resp_valid_i, dmi_resp_ready_o;
  logic [31:0]      dmi_resp_data_i;
  logic [1:0]       dmi_resp_resp_i;

  dmi_jtag_access #(.ABITS(ABITS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .dmi_update_i(dmi_update_i), .dmi_capture_i(dmi_capture_i),
    .dmi_addr_i(dmi_addr_i), .dmi_data_i(dmi_data_i), .dmi_op_i(dmi_op_i),
    .dmi_reset_i(dmi_reset_i), .dmi_hardreset_i(dmi_hardreset_i),
    .capture_addr_o(capture_addr_o), .capture_data_o(capture_data_o),
    .capture_status_o(capture_status_o), .busy_o(busy_o), .err_o(err_o),
    .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_op_o(dmi_req_op_o),
    .dmi_req_data_o(dmi_req_data_o), .dmi_resp_valid_i(dmi_resp_valid_i),
    .dmi_resp_ready_o(dmi_resp_ready_o), .dmi_resp_data_i(dmi_resp_data_i),
    .dmi_resp_resp_i(dmi_resp_resp_i)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard: expected {addr, op, data} of each request
  logic [REQ_W-1:0] exp_q[$];

  // transaction-level model of the sticky status and holding registers
  logic [1:0]       m_err;
  logic [ABITS-1:0] m_addr;
  logic [31:0]      m_data;

  typedef struct {
    logic [ABITS-1:0] a;
    logic [31:0]      d;
    logic [1:0]       op;
    logic             rst_w;
    int               rdy;
    int               rsp;
    logic [1:0]       code;
    logic [31:0]      rdata;
    int               phase;
    logic             launch;
    logic [ABITS-1:0] ca;
    logic [31:0]      cd;
    logic [1:0]       cs;
    logic [1:0]       ce;
  } vec_t;
  vec_t tbl[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_hardreset();
    dmi_hardreset_i = 1'b1;
    tick();
    dmi_hardreset_i = 1'b0;
  endtask

  task automatic extra_update();
    dmi_update_i = 1'b1;
    dmi_addr_i   = ABITS'($urandom);
    dmi_data_i   = $urandom;
    dmi_op_i     = 2'($urandom_range(1, 2));
  endtask

  // driver: one DR update, request/response handshake if launched, then a capture
  task automatic do_access(input logic [ABITS-1:0] a, input logic [31:0] d, input logic [1:0] op,
                           input logic rst_w, input int rdy, input int rsp, input logic [1:0] code,
                           input logic [31:0] rdata, input int phase, output logic launched,
                           output logic [ABITS-1:0] ca, output logic [31:0] cd, output logic [1:0] cs);
    logic [REQ_W-1:0] exp;
    dmi_update_i = 1'b1; dmi_addr_i = a; dmi_data_i = d; dmi_op_i = op; dmi_reset_i = rst_w;
    tick();
    dmi_update_i = 1'b0; dmi_reset_i = 1'b0;
    launched = dmi_req_valid_o;
    if (launched) begin
      for (int i = 0; i < rdy; i++) begin
        check("req_fields_stable", {dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o},
              {1'b1, a, op, d});
        tick();
      end
      dmi_req_ready_i = 1'b1;
      if (phase == 1) extra_update();
      check("req_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        check("req_fields", {dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o}, {1'b1, exp});
      end
      tick();
      dmi_req_ready_i = 1'b0; dmi_update_i = 1'b0;
      check("wait_state", {busy_o, dmi_req_valid_o}, 2'b10);
      for (int j = 0; j < rsp; j++) begin
        if (phase == 2 && j == 0) extra_update();
        tick();
        dmi_update_i = 1'b0;
      end
      dmi_resp_valid_i = 1'b1; dmi_resp_data_i = rdata; dmi_resp_resp_i = code;
      if (phase == 3 || (phase == 2 && rsp == 0)) extra_update();
      check("resp_ready_wait", dmi_resp_ready_o, 1'b1);
      tick();
      dmi_resp_valid_i = 1'b0; dmi_update_i = 1'b0;
      check("idle_after_resp", {busy_o, dmi_req_valid_o}, 2'b00);
    end
    dmi_capture_i = 1'b1;
    tick();
    dmi_capture_i = 1'b0;
    ca = capture_addr_o; cd = capture_data_o; cs = capture_status_o;
  endtask

  // reference model: predicts launch, status and holding registers from the access rules
  task automatic model_access(input logic [ABITS-1:0] a, input logic [31:0] d, input logic [1:0] op,
                              input logic rst_w, input logic [1:0] code, input logic [31:0] rdata,
                              input int phase, output logic exp_launch);
    if (rst_w) m_err = 2'd0;
    exp_launch = (m_err == 2'd0) && (op == 2'd1 || op == 2'd2);
    if (exp_launch) begin
      exp_q.push_back({a, op, d});
      m_addr = a;
      m_data = (op == 2'd1) ? rdata : d;
      if (phase != 0)        m_err = 2'd3;
      else if (code == 2'd1) m_err = 2'd2;
      else                   m_err = code;
    end
  endtask

  initial begin
    logic launched, exp_launch;
    logic [ABITS-1:0] ca, a;
    logic [31:0] cd, d, rdata;
    logic [1:0] cs, op, code;
    int cnt, phase;
    int codes[6] = '{0, 0, 0, 1, 2, 3};

    rst = 1'b1;
    dmi_update_i = 0; dmi_capture_i = 0; dmi_reset_i = 0; dmi_hardreset_i = 0;
    dmi_addr_i = '0; dmi_data_i = '0; dmi_op_i = '0;
    dmi_req_ready_i = 0; dmi_resp_valid_i = 0; dmi_resp_data_i = '0; dmi_resp_resp_i = '0;

    tbl[0]  = '{7'h10, 32'h12345678, 2'd2, 1'b0, 2, 1, 2'd0, 32'h0,        0, 1'b1, 7'h10, 32'h12345678, 2'd0, 2'd0};
    tbl[1]  = '{7'h04, 32'h0,        2'd1, 1'b0, 0, 0, 2'd0, 32'hDEADBEEF, 0, 1'b1, 7'h04, 32'hDEADBEEF, 2'd0, 2'd0};
    tbl[2]  = '{7'h55, 32'h1,        2'd0, 1'b0, 0, 0, 2'd0, 32'h0,        0, 1'b0, 7'h04, 32'hDEADBEEF, 2'd0, 2'd0};
    tbl[3]  = '{7'h56, 32'h2,        2'd3, 1'b0, 0, 0, 2'd0, 32'h0,        0, 1'b0, 7'h04, 32'hDEADBEEF, 2'd0, 2'd0};
    tbl[4]  = '{7'h08, 32'h0,        2'd1, 1'b0, 1, 2, 2'd0, 32'hCAFE0001, 2, 1'b1, 7'h08, 32'hCAFE0001, 2'd3, 2'd3};
    tbl[5]  = '{7'h09, 32'h0,        2'd1, 1'b0, 0, 0, 2'd0, 32'h0,        0, 1'b0, 7'h08, 32'hCAFE0001, 2'd3, 2'd3};
    tbl[6]  = '{7'h09, 32'h0,        2'd1, 1'b1, 1, 1, 2'd0, 32'h11112222, 0, 1'b1, 7'h09, 32'h11112222, 2'd0, 2'd0};
    tbl[7]  = '{7'h20, 32'hA5A5A5A5, 2'd2, 1'b0, 0, 2, 2'd2, 32'h0,        0, 1'b1, 7'h20, 32'hA5A5A5A5, 2'd2, 2'd2};
    tbl[8]  = '{7'h21, 32'h3,        2'd2, 1'b0, 0, 0, 2'd0, 32'h0,        0, 1'b0, 7'h20, 32'hA5A5A5A5, 2'd2, 2'd2};
    tbl[9]  = '{7'h22, 32'h0BADF00D, 2'd2, 1'b1, 3, 0, 2'd1, 32'h0,        0, 1'b1, 7'h22, 32'h0BADF00D, 2'd2, 2'd2};
    tbl[10] = '{7'h7F, 32'h0,        2'd1, 1'b1, 0, 1, 2'd3, 32'h55AA55AA, 0, 1'b1, 7'h7F, 32'h55AA55AA, 2'd3, 2'd3};
    tbl[11] = '{7'h01, 32'h1,        2'd2, 1'b1, 1, 1, 2'd2, 32'h0,        3, 1'b1, 7'h01, 32'h1,        2'd3, 2'd3};
    tbl[12] = '{7'h02, 32'h2,        2'd2, 1'b1, 2, 0, 2'd0, 32'h0,        1, 1'b1, 7'h02, 32'h2,        2'd3, 2'd3};
    tbl[13] = '{7'h03, 32'h0,        2'd1, 1'b1, 0, 2, 2'd0, 32'h33,       0, 1'b1, 7'h03, 32'h33,       2'd0, 2'd0};

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cap", {capture_addr_o, capture_data_o, capture_status_o}, 64'd0);
    check("rst_ctrl", {busy_o, err_o, dmi_req_valid_o, dmi_resp_ready_o, dmi_req_addr_o, dmi_req_op_o}, 64'd0);
    check("rst_req_data", dmi_req_data_o, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_resp_ready", {dmi_resp_ready_o, busy_o, dmi_req_valid_o}, 3'b100);

    // vector table
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].launch) exp_q.push_back({tbl[i].a, tbl[i].op, tbl[i].d});
      do_access(tbl[i].a, tbl[i].d, tbl[i].op, tbl[i].rst_w, tbl[i].rdy, tbl[i].rsp, tbl[i].code,
                tbl[i].rdata, tbl[i].phase, launched, ca, cd, cs);
      check("vec_launch", launched, tbl[i].launch);
      check("vec_capture", {ca, cd, cs}, {tbl[i].ca, tbl[i].cd, tbl[i].cs});
      check("vec_err", err_o, tbl[i].ce);
      check("vec_req_consumed", exp_q.size(), 0);
      exp_q.delete();
    end

    // randomized accesses against the model
    m_err = tbl[13].ce; m_addr = tbl[13].ca; m_data = tbl[13].cd;
    for (int i = 0; i < 60; i++) begin
      a     = ABITS'($urandom);
      d     = $urandom;
      op    = 2'($urandom_range(0, 3));
      rdata = $urandom;
      code  = 2'(codes[$urandom_range(0, 5)]);
      phase = $urandom_range(0, 7);
      if (phase > 3) phase = 0;
      launched = ($urandom_range(0, 3) == 0);
      model_access(a, d, op, launched, code, rdata, phase, exp_launch);
      do_access(a, d, op, launched, $urandom_range(0, 4), $urandom_range(0, 3), code, rdata, phase,
                launched, ca, cd, cs);
      check("rnd_launch", launched, exp_launch);
      check("rnd_capture", {ca, cd, cs}, {m_addr, m_data, m_err});
      check("rnd_err", err_o, m_err);
      check("rnd_req_consumed", exp_q.size(), 0);
      exp_q.delete();
    end

    // capture while busy, and capture coinciding with the response
    pulse_hardreset();
    dmi_update_i = 1; dmi_addr_i = 7'h11; dmi_data_i = 32'h44; dmi_op_i = 2'd1;
    tick();
    dmi_update_i = 0;
    check("seqa_valid", dmi_req_valid_o, 1'b1);
    dmi_capture_i = 1;
    tick();
    dmi_capture_i = 0;
    check("seqa_cap_busy", {capture_addr_o, capture_data_o, capture_status_o}, {7'h11, 32'h44, 2'd3});
    dmi_req_ready_i = 1;
    tick();
    dmi_req_ready_i = 0;
    dmi_resp_valid_i = 1; dmi_resp_data_i = 32'h99; dmi_resp_resp_i = 2'd0; dmi_capture_i = 1;
    tick();
    dmi_resp_valid_i = 0; dmi_capture_i = 0;
    check("seqa_cap_pre_resp", {capture_addr_o, capture_data_o, capture_status_o}, {7'h11, 32'h44, 2'd3});
    check("seqa_idle", busy_o, 1'b0);
    dmi_capture_i = 1;
    tick();
    dmi_capture_i = 0;
    check("seqa_cap_post", {capture_addr_o, capture_data_o, capture_status_o}, {7'h11, 32'h99, 2'd0});

    // hardreset in REQ dominates update and capture; late response dropped
    dmi_update_i = 1; dmi_addr_i = 7'h12; dmi_data_i = 32'h77; dmi_op_i = 2'd2;
    tick();
    dmi_update_i = 1; dmi_addr_i = 7'h33; dmi_op_i = 2'd1;
    tick();
    dmi_update_i = 0;
    check("seqb_busy_err", {err_o, dmi_req_valid_o, dmi_req_addr_o}, {2'd3, 1'b1, 7'h12});
    dmi_hardreset_i = 1; dmi_update_i = 1; dmi_capture_i = 1;
    tick();
    dmi_hardreset_i = 0; dmi_update_i = 0; dmi_capture_i = 0;
    check("seqb_hardreset", {dmi_req_valid_o, busy_o, err_o}, 4'b0000);
    check("seqb_cap_held", {capture_addr_o, capture_data_o, capture_status_o}, {7'h11, 32'h99, 2'd0});
    dmi_resp_valid_i = 1; dmi_resp_data_i = 32'hBB; dmi_resp_resp_i = 2'd2;
    check("seqb_late_ready", dmi_resp_ready_o, 1'b1);
    tick();
    dmi_resp_valid_i = 0;
    check("seqb_late_drop", {busy_o, err_o}, 3'b000);
    dmi_capture_i = 1;
    tick();
    dmi_capture_i = 0;
    check("seqb_cap", {capture_addr_o, capture_data_o, capture_status_o}, {7'h12, 32'h77, 2'd0});

    // request never accepted
    dmi_update_i = 1; dmi_addr_i = 7'h13; dmi_data_i = 32'h5; dmi_op_i = 2'd2;
    tick();
    dmi_update_i = 0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (dmi_req_valid_o) cnt++;
      tick();
    end
`ifdef DMI_ACCESS_TIMEOUT_EN
    check("tmo_valid_cycles", cnt, TMO);
    check("tmo_state", {busy_o, err_o}, 3'b010);
    dmi_reset_i = 1;
    tick();
    dmi_reset_i = 0;
`else
    check("no_tmo_valid_cycles", cnt, 100);
    check("no_tmo_busy", {busy_o, dmi_req_valid_o}, 2'b11);
    pulse_hardreset();
`endif
    check("after_stall_idle", busy_o, 1'b0);

    // asynchronous reset mid-access
    dmi_update_i = 1; dmi_addr_i = 7'h14; dmi_data_i = 32'h6; dmi_op_i = 2'd1;
    tick();
    dmi_update_i = 0;
    check("arst_pre_valid", dmi_req_valid_o, 1'b1);
    dmi_req_ready_i = 1;
    #2 rst = 1'b1;
    #1;
    check("arst_ctrl", {busy_o, err_o, dmi_req_valid_o, dmi_resp_ready_o, dmi_req_addr_o, dmi_req_op_o}, 64'd0);
    check("arst_cap", {capture_addr_o, capture_data_o, capture_status_o}, 64'd0);
    dmi_req_ready_i = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    check("arst_release", {dmi_resp_ready_o, busy_o, dmi_req_valid_o}, 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dmi_jtag_access.md
Name: dmi_jtag_access

Overview:
- JTAG-side DMI access controller that sits directly upstream of the DMI clock-domain crossing's request input and consumes its response output.
- Converts TAP DR-update strobes of the dmi register into one request per access over a valid/ready handshake. Holds the request until it is accepted, then waits for the response.
- Maintains the sticky DMI status (success/failed/busy) and supplies the capture value for the next DR scan.

Parameters:
- ABITS, 7, DMI address width.
- TIMEOUT_CYCLES, 1023, cycles before an outstanding access is abandoned. Used only with DMI_ACCESS_TIMEOUT_EN.

Ports:
- clk_i  in  1  JTAG clock (TCK domain).
- rst_i  in  1  asynchronous reset, active-high.
- dmi_update_i  in  1  one-cycle strobe: the dmi DR was updated.
- dmi_capture_i  in  1  one-cycle strobe: the dmi DR is being captured.
- dmi_addr_i  in  ABITS  address field from DR.
- dmi_data_i  in  32  data field from DR.
- dmi_op_i  in  2  op field: 0 nop, 1 read, 2 write, 3 reserved.
- dmi_reset_i  in  1  dtmcs.dmireset pulse.
- dmi_hardreset_i  in  1  dtmcs.dmihardreset pulse.
- capture_addr_o  out  ABITS  captured address.
- capture_data_o  out  32  captured data.
- capture_status_o  out  2  captured op/status.
- busy_o  out  1  access outstanding (state != IDLE).
- err_o  out  2  current sticky error, for dtmcs.dmistat.
- dmi_req_valid_o  out  1  request valid.
- dmi_req_ready_i  in  1  request accepted.
- dmi_req_addr_o  out  ABITS  request address.
- dmi_req_op_o  out  2  1 read, 2 write.
- dmi_req_data_o  out  32  request write data.
- dmi_resp_valid_i  in  1  response valid.
- dmi_resp_ready_o  out  1  response accepted.
- dmi_resp_data_i  in  32  response read data.
- dmi_resp_resp_i  in  2  response code: 0 ok, 2 failed, 3 busy.

Behaviour:
- Reset: every output is 0; state IDLE; err=0; the addr/data/op holding registers are 0.
- States:
  - IDLE: dmi_resp_ready_o=1. Any response arriving here is accepted and discarded (late response after an abort).
  - REQ: dmi_req_valid_o=1. addr/op/data are held stable from the holding registers. When ready=1 in a cycle, the next state is WAIT_RESP.
  - WAIT_RESP: dmi_resp_ready_o=1. When valid=1, the next state is IDLE.
- Request launch, in IDLE:
  - Launch occurs on dmi_update_i=1 with err==0 and op in {1,2}.
  - The DR fields are latched and the next cycle is REQ; dmi_req_valid_o rises one cycle after the update.
  - op 0 or 3: no action.
  - err!=0: the update is ignored.
- Response handling, in WAIT_RESP on dmi_resp_valid_i:
  - For a read, the data holding register is loaded from dmi_resp_data_i.
  - If resp!=0 and err==0, err is loaded from resp.
  - resp 1 is treated as 2.
- Update while busy: if dmi_update_i=1 in REQ or WAIT_RESP and err==0, err is set to 3. No new request is issued. The outstanding access completes normally.
- Capture: on dmi_capture_i, the capture outputs register the held addr and data, 1-cycle latency.
  - status = err if err!=0.
  - Otherwise status = 3 if state!=IDLE.
  - Otherwise status = 0.
- dmi_reset_i: clears err only. The state machine is unaffected.
- dmi_hardreset_i: next state IDLE, err cleared, dmi_req_valid_o drops next cycle. Any outstanding response is dropped in IDLE.
- Simultaneous events:
  - hardreset dominates update and capture.
  - dmi_reset together with update: the clear is applied first, and the update is evaluated against err==0.
  - Response completion together with update in WAIT_RESP: counts as busy, so err is set to 3; the state still goes to IDLE.
  - Capture together with response completion: the capture reflects the pre-update registers.
- Asynchronous reset mid-access: immediate return to the reset values; no handshake completion.

Optional Feature:
- Macro: DMI_ACCESS_TIMEOUT_EN.
- Defined:
  - An ceil(log2(TIMEOUT_CYCLES+1))-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT_RESP.
  - When the counter reaches TIMEOUT_CYCLES without completion: next state IDLE, err set to 2 if err==0, dmi_req_valid_o deasserted.
  - A late response is discarded in IDLE.
- Not defined: no counter; an access waits indefinitely.

Test Plan:
- Write 0x12345678 to addr 0x10 (op 2), ready after 3 cycles, resp 0 -> one request with valid held 3 cycles and fields stable; next capture status 0 with data 0x12345678.
- Read addr 0x04 (op 1), resp data 0xDEADBEEF, resp 0 -> capture_data_o=0xDEADBEEF, capture_addr_o=0x04, status 0.
- Second update while in WAIT_RESP -> err=3, exactly one request issued; later reads ignored until dmi_reset_i, after which a read succeeds.
- Response code 2 on a write -> err=2, capture status 2; dmi_hardreset_i in REQ -> valid drops next cycle, err=0, late response dropped.
- With DMI_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=8, ready held 0 -> IDLE after 8 cycles, err=2; without the macro, still in REQ after 100 cycles.
